// File: rtl/sap2_bus_pkg.sv
// Shared helpers for the SAP2 bus arbiter and its round-robin selector.
package sap2_bus_pkg;

  // Defaults used when nothing overrides the requester count.
  localparam int unsigned DefaultNReq         = 4;
  localparam int unsigned DefaultLastGrantRst = DefaultNReq - 1;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned dst_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // last_grant resets to the top requester so that requester 0 wins the first scan.
  function automatic int unsigned last_grant_rst(input int unsigned n_req);
    return n_req - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible index after i_last_grant, wrapping.
module rr_pick
  import sap2_bus_pkg::*;
#(
  parameter  int unsigned N_REQ = DefaultNReq,
  localparam int unsigned IW    = dst_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [IW-1:0]    i_last_grant,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_index,
  output logic             o_valid
);

  logic          w_hi_found;
  logic          w_lo_found;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest eligible index above last_grant, else lowest eligible overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!w_hi_found && i_eligible[k] && (IW'(k) > i_last_grant)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IW'(k);
      end
      if (!w_lo_found && i_eligible[k]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(k);
      end
    end
  end

  always_comb begin
    o_valid  = w_hi_found | w_lo_found;
    o_index  = w_hi_found ? w_hi_idx : w_lo_idx;
    o_onehot = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      o_onehot[k] = o_valid && (o_index == IW'(k));
    end
  end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin owner of the SAP2 data bus with lock chaining and per-destination load enables.
module bus_transfer_arbiter
  import sap2_bus_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned N_DST    = 4,
  parameter  int unsigned MAX_LOCK = 4,
  localparam int unsigned DW       = dst_width(N_DST)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_lock,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ*DW-1:0]    i_req_dst,
  output logic [WIDTH-1:0]       o_bus_data,
  output logic [N_DST-1:0]       o_load_enable,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned IW = dst_width(N_REQ);
  localparam int unsigned CW = dst_width(MAX_LOCK);

  logic [WIDTH-1:0] r_bus_data;
  logic [N_DST-1:0] r_load_enable;
  logic [N_REQ-1:0] r_ack;
  logic             r_busy;
  logic             r_err;
  logic [IW-1:0]    r_last_grant;
  logic [CW-1:0]    r_lock_cnt;

  logic [N_REQ-1:0] w_eligible;
  logic [N_REQ-1:0] w_rr_onehot;
  logic [IW-1:0]    w_rr_index;
  logic             w_rr_valid;
  logic             w_g_lock;
  logic             w_lock_ok;
  logic             w_win;
  logic [IW-1:0]    w_win_idx;
  logic [N_REQ-1:0] w_win_onehot;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_data;
  logic [DW-1:0]    w_dst;
  logic             w_dst_ok;
  logic [N_DST-1:0] w_le;

  // The current owner is excluded from the scan; it can only chain through the lock path.
  assign w_eligible = i_req & ~r_ack;
  assign w_g_lock   = (|r_ack) & i_req[r_last_grant] & i_lock[r_last_grant];
  assign w_lock_ok  = w_g_lock & (r_lock_cnt < CW'(MAX_LOCK - 1));

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_onehot     (w_rr_onehot),
    .o_index      (w_rr_index),
    .o_valid      (w_rr_valid)
  );

  always_comb begin
    w_win        = 1'b0;
    w_win_idx    = r_last_grant;
    w_win_onehot = '0;
    w_cnt_next   = '0;
    if (w_lock_ok) begin
      w_win        = 1'b1;
      w_win_onehot = r_ack;
      w_cnt_next   = r_lock_cnt + CW'(1);
    end else if (w_rr_valid) begin
      w_win        = 1'b1;
      w_win_idx    = w_rr_index;
      w_win_onehot = w_rr_onehot;
    end else if (w_g_lock) begin
      // Lock cap reached but nobody else wants the bus: keep granting, counter saturates.
      w_win        = 1'b1;
      w_win_onehot = r_ack;
      w_cnt_next   = r_lock_cnt;
    end
  end

  always_comb begin
    w_data = '0;
    w_dst  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_win_idx == IW'(k)) begin
        w_data = i_req_data[k*WIDTH +: WIDTH];
        w_dst  = i_req_dst[k*DW +: DW];
      end
    end
  end

  always_comb begin
    w_dst_ok = ({1'b0, w_dst} < (DW + 1)'(N_DST));
    w_le     = '0;
    for (int d = 0; d < int'(N_DST); d++) begin
      w_le[d] = w_dst_ok && (w_dst == DW'(d));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_data    <= '0;
      r_load_enable <= '0;
      r_ack         <= '0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_last_grant  <= IW'(last_grant_rst(N_REQ));
      r_lock_cnt    <= '0;
    end else if (clk_en) begin
      r_lock_cnt <= w_cnt_next;
      if (w_win) begin
        r_bus_data    <= w_data;
        r_load_enable <= w_le;
        r_ack         <= w_win_onehot;
        r_busy        <= 1'b1;
        r_err         <= ~w_dst_ok;
        r_last_grant  <= w_win_idx;
      end else begin
        r_load_enable <= '0;
        r_ack         <= '0;
        r_busy        <= 1'b0;
        r_err         <= 1'b0;
      end
    end
  end

  assign o_bus_data    = r_bus_data;
  assign o_load_enable = r_load_enable;
  assign o_ack         = r_ack;
  assign o_busy        = r_busy;
  assign o_err         = r_err;

endmodule
